// File: rtl/rope_chain.sv
// Rope chain relaxation engine: node 0 follows the mouse anchor, nodes 1..N-1 relax
// in Gauss-Seidel sweeps. Define ROPE_CHAIN_GRAVITY_EN to add a per-sweep gravity step to y.
module rope_chain #(
    parameter int                 N_NODES     = 20,
    parameter int                 ITERATIONS  = 2,
    parameter int                 STIFF_SHIFT = 2,
    parameter int                 SPACING     = 8,
    parameter logic signed [31:0] GRAVITY     = 32'sh0000_0400
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [9:0]              in_mouse_x,
    input  logic [9:0]              in_mouse_y,
    output logic                    busy,
    output logic                    done,
    output logic [N_NODES*10-1:0]   nodes_x,
    output logic [N_NODES*10-1:0]   nodes_y
);

    // state  | meaning
    // IDLE   | waiting for start; outputs hold last snapshot
    // ANCHOR | latch clamped mouse position into node 0
    // RELAX  | update one node per cycle, ITERATIONS sweeps over 1..N_NODES-1
    // DONE   | copy positions to outputs, pulse done
    typedef enum logic [1:0] {IDLE, ANCHOR, RELAX, DONE} state_t;

    localparam int                   IDX_W    = $clog2(N_NODES);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_NODES - 1);
    localparam logic [9:0]           MAX_X    = 10'd639;
    localparam logic [9:0]           MAX_Y    = 10'd479;
    localparam logic [9:0]           RST_X    = 10'd320;

`ifdef ROPE_CHAIN_GRAVITY_EN
    localparam logic signed [33:0]   GRAV_TERM = 34'(GRAVITY);
`else
    // gravity disabled: the term is forced to zero
    localparam logic signed [33:0]   GRAV_TERM = 34'(GRAVITY) & 34'sd0;
`endif

    state_t                 state, next_state;
    logic [IDX_W-1:0]       node_idx;
    logic [3:0]             sweep_left;
    logic signed [31:0]     pos_x [N_NODES];
    logic signed [31:0]     pos_y [N_NODES];

    logic                   is_last;
    logic [IDX_W-1:0]       prev_idx, next_idx;
    logic signed [33:0]     cur_x, prv_x, nxt_x, sum_x, upd_x;
    logic signed [33:0]     cur_y, prv_y, nxt_y, sum_y, upd_y;
    logic signed [31:0]     new_x, new_y;
    logic [9:0]             mouse_x_c, mouse_y_c;

    function automatic logic [9:0] reset_y_px(input int k);
        int v;
        v = k * SPACING;
        if (v > 479) v = 479;
        return v[9:0];
    endfunction

    // Negative results snap to 0.0; anything past the last pixel snaps to that pixel's origin.
    function automatic logic signed [31:0] clamp_pos(input logic signed [33:0] v,
                                                     input logic [9:0] max_px);
        logic signed [33:0] lim;
        lim = $signed({12'd0, max_px, 12'd0}) + 34'sd4096;
        if (v < 34'sd0)
            return '0;
        else if (v >= lim)
            return $signed({10'd0, max_px, 12'd0});
        else
            return v[31:0];
    endfunction

    always_comb begin
        is_last  = (node_idx == LAST_IDX);
        prev_idx = node_idx - IDX_W'(1);
        next_idx = is_last ? node_idx : node_idx + IDX_W'(1);

        cur_x = {{2{pos_x[node_idx][31]}}, pos_x[node_idx]};
        prv_x = {{2{pos_x[prev_idx][31]}}, pos_x[prev_idx]};
        nxt_x = {{2{pos_x[next_idx][31]}}, pos_x[next_idx]};
        cur_y = {{2{pos_y[node_idx][31]}}, pos_y[node_idx]};
        prv_y = {{2{pos_y[prev_idx][31]}}, pos_y[prev_idx]};
        nxt_y = {{2{pos_y[next_idx][31]}}, pos_y[next_idx]};

        if (is_last) begin
            sum_x = prv_x - cur_x;
            sum_y = prv_y - cur_y;
        end else begin
            sum_x = prv_x + nxt_x - (cur_x <<< 1);
            sum_y = prv_y + nxt_y - (cur_y <<< 1);
        end

        upd_x = cur_x + (sum_x >>> STIFF_SHIFT);
        upd_y = cur_y + (sum_y >>> STIFF_SHIFT) + GRAV_TERM;
        new_x = clamp_pos(upd_x, MAX_X);
        new_y = clamp_pos(upd_y, MAX_Y);

        mouse_x_c = (in_mouse_x > MAX_X) ? MAX_X : in_mouse_x;
        mouse_y_c = (in_mouse_y > MAX_Y) ? MAX_Y : in_mouse_y;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ANCHOR;
            ANCHOR:  next_state = RELAX;
            RELAX:   if (is_last && sweep_left == 4'd0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            node_idx   <= IDX_W'(1);
            sweep_left <= 4'd0;
            for (int k = 0; k < N_NODES; k++) begin
                pos_x[k]             <= $signed({10'd0, RST_X, 12'd0});
                pos_y[k]             <= $signed({10'd0, reset_y_px(k), 12'd0});
                nodes_x[k*10 +: 10]  <= RST_X;
                nodes_y[k*10 +: 10]  <= reset_y_px(k);
            end
        end else begin
            case (state)
                ANCHOR: begin
                    pos_x[0]   <= $signed({10'd0, mouse_x_c, 12'd0});
                    pos_y[0]   <= $signed({10'd0, mouse_y_c, 12'd0});
                    node_idx   <= IDX_W'(1);
                    sweep_left <= 4'(ITERATIONS - 1);
                end
                RELAX: begin
                    pos_x[node_idx] <= new_x;
                    pos_y[node_idx] <= new_y;
                    if (is_last) begin
                        node_idx <= IDX_W'(1);
                        if (sweep_left != 4'd0)
                            sweep_left <= sweep_left - 4'd1;
                    end else begin
                        node_idx <= node_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    for (int k = 0; k < N_NODES; k++) begin
                        nodes_x[k*10 +: 10] <= pos_x[k][21:12];
                        nodes_y[k*10 +: 10] <= pos_y[k][21:12];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rope_chain.sv
// Bench for rope_chain: a 4-node instance checked against a reference model through
// a frame scoreboard, plus a default-parameter instance for latency and settling.
module tb_rope_chain;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_s, start_d;
    logic [9:0]   mouse_x, mouse_y;
    logic         busy_s, done_s, busy_d, done_d;
    logic [39:0]  nx_s, ny_s;
    logic [199:0] nx_d, ny_d;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt_s   = 0;
    int done_cnt_d   = 0;

`ifdef ROPE_CHAIN_GRAVITY_EN
    localparam longint     G_UNITS = 4096;
    localparam logic [39:0] SPEC_Y = {10'd21, 10'd17, 10'd9, 10'd0};
`else
    localparam longint     G_UNITS = 0;
    localparam logic [39:0] SPEC_Y = {10'd20, 10'd16, 10'd8, 10'd0};
`endif
    localparam logic [39:0] RST_X_S = {4{10'd320}};
    localparam logic [39:0] RST_Y_S = {10'd24, 10'd16, 10'd8, 10'd0};

    typedef struct packed {
        logic [39:0] x;
        logic [39:0] y;
    } frame_t;

    frame_t       sb[$];
    longint       mx[4], my[4];
    logic [199:0] rst_x_d, rst_y_d;

    rope_chain #(.N_NODES(4), .ITERATIONS(1), .STIFF_SHIFT(1), .SPACING(8),
                 .GRAVITY(32'sh0000_1000)) dut_s (
        .clk(clk), .reset(reset), .start(start_s),
        .in_mouse_x(mouse_x), .in_mouse_y(mouse_y),
        .busy(busy_s), .done(done_s), .nodes_x(nx_s), .nodes_y(ny_s));

    rope_chain dut_d (
        .clk(clk), .reset(reset), .start(start_d),
        .in_mouse_x(mouse_x), .in_mouse_y(mouse_y),
        .busy(busy_d), .done(done_d), .nodes_x(nx_d), .nodes_y(ny_d));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done_s === 1'b1) done_cnt_s <= done_cnt_s + 1;
        if (done_d === 1'b1) done_cnt_d <= done_cnt_d + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic longint mclamp(input longint v, input longint maxpx);
        if (v < 0) return 0;
        if ((v >>> 12) > maxpx) return maxpx * 4096;
        return v;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            mx[k] = 320 * 4096;
            my[k] = k * 8 * 4096;
        end
    endfunction

    function automatic void model_frame(input int x, input int y);
        longint dx, dy;
        mx[0] = longint'((x > 639) ? 639 : x) * 4096;
        my[0] = longint'((y > 479) ? 479 : y) * 4096;
        for (int i = 1; i < 4; i++) begin
            if (i == 3) begin
                dx = mx[2] - mx[3];
                dy = my[2] - my[3];
            end else begin
                dx = mx[i-1] + mx[i+1] - 2 * mx[i];
                dy = my[i-1] + my[i+1] - 2 * my[i];
            end
            mx[i] = mclamp(mx[i] + (dx >>> 1), 639);
            my[i] = mclamp(my[i] + (dy >>> 1) + G_UNITS, 479);
        end
    endfunction

    function automatic int adj_dist(input logic [199:0] xs, input logic [199:0] ys);
        int best, d, a, b;
        best = 0;
        for (int k = 1; k < 20; k++) begin
            a = int'(xs[k*10 +: 10]) - int'(xs[(k-1)*10 +: 10]);
            b = int'(ys[k*10 +: 10]) - int'(ys[(k-1)*10 +: 10]);
            d = (a < 0 ? -a : a) + (b < 0 ? -b : b);
            if (d > best) best = d;
        end
        return best;
    endfunction

    function automatic int frame_delta(input logic [199:0] xa, input logic [199:0] ya,
                                       input logic [199:0] xb, input logic [199:0] yb);
        int s, a, b;
        s = 0;
        for (int k = 0; k < 20; k++) begin
            a = int'(xa[k*10 +: 10]) - int'(xb[k*10 +: 10]);
            b = int'(ya[k*10 +: 10]) - int'(yb[k*10 +: 10]);
            s += (a < 0 ? -a : a) + (b < 0 ? -b : b);
        end
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        sb.delete();
    endtask

    task automatic run_frame_s(input int x, input int y, input bit inject);
        frame_t e;
        int     cyc, dc0;
        bit     busy_ok;
        model_frame(x, y);
        for (int k = 0; k < 4; k++) begin
            e.x[k*10 +: 10] = 10'(mx[k] >>> 12);
            e.y[k*10 +: 10] = 10'(my[k] >>> 12);
        end
        sb.push_back(e);
        @(negedge clk);
        mouse_x = x[9:0];
        mouse_y = y[9:0];
        start_s = 1'b1;
        dc0 = done_cnt_s;
        @(negedge clk);
        start_s = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (done_s !== 1'b1 && cyc < 50) begin
            if (busy_s !== 1'b1) busy_ok = 1'b0;
            if (inject && cyc == 3) start_s = 1'b1;
            @(negedge clk);
            start_s = 1'b0;
            cyc++;
        end
        tests_run++;
        if (cyc != 5) begin
            tests_failed++;
            $display("FAIL latency_s: got %0d cycles, expected 5", cyc);
        end
        tests_run++;
        if (!busy_ok) begin
            tests_failed++;
            $display("FAIL busy_during_frame_s: busy dropped before done, expected high");
        end
        @(negedge clk);
        tests_run++;
        if (done_s !== 1'b0 || busy_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_done_s: done=%b busy=%b, expected 0 0", done_s, busy_s);
        end
        e = sb.pop_front();
        tests_run++;
        if (nx_s !== e.x) begin
            tests_failed++;
            $display("FAIL nodes_x_s: got %h expected %h", nx_s, e.x);
        end
        tests_run++;
        if (ny_s !== e.y) begin
            tests_failed++;
            $display("FAIL nodes_y_s: got %h expected %h", ny_s, e.y);
        end
        if (inject) repeat (10) @(negedge clk);
        tests_run++;
        if (done_cnt_s != dc0 + 1) begin
            tests_failed++;
            $display("FAIL done_pulses_s: got %0d pulses, expected 1", done_cnt_s - dc0);
        end
    endtask

    task automatic run_frame_d(input int x, input int y);
        int cyc;
        @(negedge clk);
        mouse_x = x[9:0];
        mouse_y = y[9:0];
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        cyc = 1;
        while (done_d !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (cyc != 40) begin
            tests_failed++;
            $display("FAIL latency_d: got %0d cycles, expected 40", cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        tests_run++;
        if (busy_s !== 1'b0 || done_s !== 1'b0 || busy_d !== 1'b0 || done_d !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: busy_s=%b done_s=%b busy_d=%b done_d=%b, expected 0",
                     busy_s, done_s, busy_d, done_d);
        end
        tests_run++;
        if (nx_s !== RST_X_S || ny_s !== RST_Y_S) begin
            tests_failed++;
            $display("FAIL reset_nodes_s: got x=%h y=%h expected x=%h y=%h",
                     nx_s, ny_s, RST_X_S, RST_Y_S);
        end
        tests_run++;
        if (nx_d !== rst_x_d || ny_d !== rst_y_d) begin
            tests_failed++;
            $display("FAIL reset_nodes_d: got y=%h expected y=%h", ny_d, rst_y_d);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_spec_frame();
        do_reset();
        run_frame_s(320, 0, 1'b0);
        tests_run++;
        if (nx_s !== RST_X_S || ny_s !== SPEC_Y) begin
            tests_failed++;
            $display("FAIL spec_frame: got x=%h y=%h expected x=%h y=%h",
                     nx_s, ny_s, RST_X_S, SPEC_Y);
        end
    endtask

    task automatic test_clamp();
        bit in_range;
        run_frame_s(1000, 600, 1'b0);
        tests_run++;
        if (nx_s[9:0] !== 10'd639 || ny_s[9:0] !== 10'd479) begin
            tests_failed++;
            $display("FAIL anchor_clamp: got (%0d,%0d) expected (639,479)", nx_s[9:0], ny_s[9:0]);
        end
        in_range = 1'b1;
        for (int k = 0; k < 4; k++)
            if (nx_s[k*10 +: 10] > 10'd639 || ny_s[k*10 +: 10] > 10'd479) in_range = 1'b0;
        tests_run++;
        if (!in_range) begin
            tests_failed++;
            $display("FAIL bounds_s: x=%h y=%h exceed 639/479", nx_s, ny_s);
        end
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 10; n++)
            run_frame_s(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0);
    endtask

    task automatic test_start_ignored();
        run_frame_s(200, 300, 1'b1);
        tests_run++;
        if (busy_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignored_start_busy: got %b expected 0", busy_s);
        end
    endtask

    task automatic test_back_to_back();
        run_frame_s(50, 460, 1'b0);
        run_frame_s(630, 5, 1'b0);
        run_frame_s(320, 240, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        int dc0;
        @(negedge clk);
        mouse_x = 10'd500;
        mouse_y = 10'd400;
        start_s = 1'b1;
        dc0 = done_cnt_s;
        @(negedge clk);
        start_s = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++;
        if (busy_s !== 1'b0 || done_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_flags: busy=%b done=%b expected 0 0", busy_s, done_s);
        end
        tests_run++;
        if (nx_s !== RST_X_S || ny_s !== RST_Y_S) begin
            tests_failed++;
            $display("FAIL midreset_nodes: got x=%h y=%h expected x=%h y=%h",
                     nx_s, ny_s, RST_X_S, RST_Y_S);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        sb.delete();
        repeat (10) @(negedge clk);
        tests_run++;
        if (done_cnt_s != dc0 || busy_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_no_done: got %0d pulses busy=%b expected 0 pulses busy 0",
                     done_cnt_s - dc0, busy_s);
        end
        run_frame_s(320, 0, 1'b0);
        tests_run++;
        if (ny_s !== SPEC_Y) begin
            tests_failed++;
            $display("FAIL restart_after_reset: got y=%h expected %h", ny_s, SPEC_Y);
        end
    endtask

    task automatic test_converge_small();
        logic [39:0] px, py;
        do_reset();
        px = '0;
        py = '0;
        for (int n = 0; n < 200; n++) begin
            px = nx_s;
            py = ny_s;
            run_frame_s(100, 50, 1'b0);
        end
        tests_run++;
        if (nx_s !== px || ny_s !== py) begin
            tests_failed++;
            $display("FAIL converge_small: got x=%h y=%h expected unchanged x=%h y=%h",
                     nx_s, ny_s, px, py);
        end
    endtask

    task automatic test_converge_default();
        logic [199:0] x1, y1, xp, yp;
        int           delta_first, delta_last, dist_first, dist_last;
        bit           in_range;
        do_reset();
        run_frame_d(100, 50);
        x1 = nx_d;
        y1 = ny_d;
        dist_first = adj_dist(nx_d, ny_d);
        run_frame_d(100, 50);
        delta_first = frame_delta(nx_d, ny_d, x1, y1);
        xp = nx_d;
        yp = ny_d;
        for (int n = 2; n < 200; n++) begin
            xp = nx_d;
            yp = ny_d;
            run_frame_d(100, 50);
        end
        delta_last = frame_delta(nx_d, ny_d, xp, yp);
        dist_last  = adj_dist(nx_d, ny_d);
        tests_run++;
        if (nx_d[9:0] !== 10'd100 || ny_d[9:0] !== 10'd50) begin
            tests_failed++;
            $display("FAIL anchor_d: got (%0d,%0d) expected (100,50)", nx_d[9:0], ny_d[9:0]);
        end
        in_range = 1'b1;
        for (int k = 0; k < 20; k++)
            if (nx_d[k*10 +: 10] > 10'd639 || ny_d[k*10 +: 10] > 10'd479) in_range = 1'b0;
        tests_run++;
        if (!in_range) begin
            tests_failed++;
            $display("FAIL bounds_d: outputs exceed 639/479");
        end
        tests_run++;
        if (delta_first == 0 || delta_last > delta_first) begin
            tests_failed++;
            $display("FAIL settle_motion_d: last frame change %0d, first frame change %0d, expected last <= first and first > 0",
                     delta_last, delta_first);
        end
        tests_run++;
        if (dist_last > dist_first) begin
            tests_failed++;
            $display("FAIL settle_spacing_d: final max spacing %0d, expected <= initial %0d",
                     dist_last, dist_first);
        end
    endtask

    initial begin
        start_s = 1'b0;
        start_d = 1'b0;
        mouse_x = '0;
        mouse_y = '0;
        for (int k = 0; k < 20; k++) begin
            rst_x_d[k*10 +: 10] = 10'd320;
            rst_y_d[k*10 +: 10] = 10'(k * 8);
        end
        test_reset();
        test_spec_frame();
        test_clamp();
        test_random_frames();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_frame();
        test_converge_small();
        test_converge_default();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rope_chain.md
ROPE_CHAIN -- requirements
Module: rope_chain

Interface
REQ-001 Parameter N_NODES, default 20, node count including anchor node 0; legal range 3..64.
REQ-002 Parameter ITERATIONS, default 2, relaxation sweeps per frame; legal range 1..8.
REQ-003 Parameter STIFF_SHIFT, default 2, arithmetic right-shift applied to the spring term.
REQ-004 Parameter SPACING, default 8, reset vertical pixel spacing between nodes.
REQ-005 Parameter GRAVITY, default 32'sh0000_0400 (0.25 px), per-node per-sweep downward step in 20.12 fixed point.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  single-cycle frame request; sampled only in IDLE.
REQ-009 in_mouse_x  in  10  anchor x target, pixels.
REQ-010 in_mouse_y  in  10  anchor y target, pixels.
REQ-011 busy  out  1  high from the cycle after start is accepted until DONE ends.
REQ-012 done  out  1  one-cycle pulse in the DONE state.
REQ-013 nodes_x  out  N_NODES*10  packed pixel x, node k at bits [k*10+9:k*10].
REQ-014 nodes_y  out  N_NODES*10  packed pixel y, same packing.

Function
REQ-015 Internal positions SHALL be 32-bit signed 20.12 fixed point; pixel value = bits [21:12].
REQ-016 FSM states SHALL be IDLE, ANCHOR, RELAX, DONE.
REQ-017 IDLE -> ANCHOR when start=1; start in any other state SHALL be ignored, with no queuing.
REQ-018 ANCHOR (1 cycle) SHALL latch node 0 = {mouse, 12'b0}; x is clamped to 639 and y to 479.
REQ-019 RELAX SHALL update one node per cycle: index 1..N_NODES-1, repeated ITERATIONS times (ITERATIONS*(N_NODES-1) cycles).
REQ-020 Interior node i SHALL update as p_i += (p_{i-1} + p_{i+1} - 2*p_i) >>> STIFF_SHIFT.
  - p_{i-1} is the value already updated this sweep (Gauss-Seidel); p_{i+1} is the old value.
REQ-021 The last node SHALL update as p_last += (p_{last-1} - p_last) >>> STIFF_SHIFT.
REQ-022 Each updated position SHALL be clamped to pixel ranges x 0..639 and y 0..479; a negative result clamps to 0 with zero fraction.
REQ-023 DONE (1 cycle) SHALL copy all positions into the nodes_x/nodes_y output registers, pulse done, then return to IDLE.
REQ-024 Outputs SHALL change only in DONE, giving frame-coherent snapshots.
REQ-025 Latency from the start-accept edge to the done pulse SHALL be exactly 2 + ITERATIONS*(N_NODES-1) cycles.
REQ-026 Intermediate sums SHALL be computed at 34 bits before the shift, so they cannot overflow.

Reset
REQ-027 On reset, the FSM SHALL go to IDLE, with busy=0 and done=0.
REQ-028 On reset, node k SHALL be set to x=320, y=k*SPACING (clamped to 479), fraction 0, and outputs SHALL equal these values.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately; no done pulse is produced.

Configuration
REQ-030 Macro ROPE_CHAIN_GRAVITY_EN:
  - Defined: GRAVITY is added to y after the spring term for nodes 1..N_NODES-1, before the clamp.
  - Undefined: no gravity term; the GRAVITY parameter is unused.

Verification
REQ-031 N=4, ITER=1, SHIFT=1, no gravity, start with mouse (320,0) -> done 5 cycles after accept; y=0,8,16,20; all x=320.
REQ-032 Same setup with ROPE_CHAIN_GRAVITY_EN and GRAVITY=4096 -> y=0,9,17,21.
REQ-033 Mouse (1000,600) -> node 0 pixel = (639,479); no output exceeds those bounds.
REQ-034 start pulsed during RELAX -> ignored; exactly one done pulse per accepted start; busy low in the cycle after done.
REQ-035 reset asserted mid-RELAX -> busy=0, no done pulse, outputs return to reset pattern (320, k*SPACING) within one cycle.
REQ-036 Default parameters, 200 frames with mouse fixed at (100,50) -> node-to-node distances settle and outputs stay unchanged after convergence.
